serial_logic_unit: RTL and testbench

Bit-serial two-operand logic unit that sits directly downstream of the single-bit OR gate and its sibling gates. Operands are presented in parallel. The unit walks them LSB-first, one bit per cycle, through one gate cell and assembles the parallel result. This is the first clocked consumer of the gate library and the building block for the later ALU/register stages.

---
 rtl/gates_pkg.sv | 18 +
 rtl/and_gate.sv | 8 +
 rtl/bit_logic_cell.sv | 32 +++
 rtl/nand_gate.sv | 8 +
 rtl/or_gate.sv | 8 +
 rtl/xor_gate.sv | 8 +
 rtl/serial_logic_unit.sv | 147 ++++++++++++++
 tb/tb_serial_logic_unit.sv | 199 +++++++++++++++++++
 8 files changed

// File: rtl/gates_pkg.sv
// Shared types for the gate library and its first clocked consumer:
// operation select codes and the serial unit's state encoding.
package gates_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/and_gate.sv
// Single-bit AND gate from the gate library.
module and_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// File: rtl/bit_logic_cell.sv
// Combinational 1-bit logic cell: evaluates all four library gates on
// (x, y) in parallel and picks one with a 4:1 select driven by op.
module bit_logic_cell
    import gates_pkg::*;
(
    input  logic x,
    input  logic y,
    input  op_e  op,
    output logic z
);
    logic and_s;
    logic or_s;
    logic xor_s;
    logic nand_s;

    and_gate  u_and  (.a(x), .b(y), .y(and_s));
    or_gate   u_or   (.a(x), .b(y), .y(or_s));
    xor_gate  u_xor  (.a(x), .b(y), .y(xor_s));
    nand_gate u_nand (.a(x), .b(y), .y(nand_s));

    // 4:1 select of the gate outputs by operation code
    always_comb begin
        z = 1'b0;
        case (op)
            OP_AND:  z = and_s;
            OP_OR:   z = or_s;
            OP_XOR:  z = xor_s;
            OP_NAND: z = nand_s;
            default: z = 1'b0;
        endcase
    end
endmodule

// File: rtl/nand_gate.sv
// Single-bit NAND gate from the gate library.
module nand_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// File: rtl/or_gate.sv
// Single-bit OR gate from the gate library.
module or_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

// File: rtl/xor_gate.sv
// Single-bit XOR gate from the gate library.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial two-operand logic unit. Operands are captured in parallel on
// an accepted start, walked LSB-first through one bit_logic_cell per cycle,
// and the assembled word is published on result with a one-cycle done.
// Optional feature macro: SERIAL_LOGIC_ZERO_FLAG_EN adds a registered zero
// flag that is updated together with result.
module serial_logic_unit
    import gates_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_r;
    state_e           state_s;
    op_e              op_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    // Only the upper WIDTH-1 bits are kept: the bit that would sit at
    // position 0 is always shifted out before it could be observed.
    logic [WIDTH-1:1] acc_r;
    logic [WIDTH-1:0] acc_next_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             busy_r;
    logic             done_r;
    logic             bit_s;
    logic             last_s;

    bit_logic_cell u_cell (
        .x  (a_sh_r[0]),
        .y  (b_sh_r[0]),
        .op (op_r),
        .z  (bit_s)
    );

    assign acc_next_s = {bit_s, acc_r};
    assign last_s     = (cnt_r == CNT_LAST);

    // Next-state decode; start only matters while idle
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register plus registered busy/done derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != S_IDLE);
            done_r  <= (state_s == S_DONE);
        end
    end

    // Operand capture, serial shifting, bit counter and result publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= OP_AND;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            acc_r    <= {(WIDTH-1){1'b0}};
            cnt_r    <= {CW{1'b0}};
            result_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        op_r   <= op_e'(op);
                        a_sh_r <= a;
                        b_sh_r <= b;
                        acc_r  <= {(WIDTH-1){1'b0}};
                        cnt_r  <= {CW{1'b0}};
                    end
                end
                S_RUN: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    acc_r  <= acc_next_s[WIDTH-1:1];
                    if (last_s) begin
                        result_r <= acc_next_s;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic zero_r;

    // Zero flag tracks the published result; reset agrees with result = 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r <= 1'b1;
        end else if ((state_r == S_RUN) && last_s) begin
            zero_r <= (acc_next_s == {WIDTH{1'b0}});
        end else begin
            zero_r <= zero_r;
        end
    end

    assign zero = zero_r;
`endif

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit (WIDTH=16). A word-level model
// predicts busy/done/result from the accept edge and an edge count; a
// compare process checks it every cycle, and directed steps pin literal
// results and latencies.
module tb_serial_logic_unit;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic         zero;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit cmp_en   = 1'b0;

    serial_logic_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    // Model: phase 0 = idle, 1..W = edges spent since accept, W+1 = done cycle
    int           m_phase = 0;
    logic [W-1:0] m_pend  = '0;
    logic [W-1:0] m_res   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_pend  <= '0;
            m_res   <= '0;
        end else if (m_phase == 0) begin
            if (start === 1'b1) begin
                m_phase <= 1;
                m_pend  <= word_op(op, a, b);
            end
        end else if (m_phase < W) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == W) begin
            m_res   <= m_pend;
            m_phase <= W + 1;
        end else begin
            m_phase <= 0;
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", 64'(busy), 64'(m_phase != 0));
            chk("cyc_done", 64'(done), 64'(m_phase == W + 1));
            chk("cyc_result", 64'(result), 64'(m_res));
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
            chk("cyc_zero", 64'(zero), 64'(m_res == '0));
`endif
        end
    end

    // Issue one operation at the current negedge; wait for done, check
    // latency and result, then step to the first idle cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp, input string nm, input bit inject);
        int k;
        bit seen;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y; op = ~o;
        chk({nm, "_busy_after_accept"}, 64'(busy), 64'd1);
        k = 1;
        seen = 1'b0;
        while (k < 40 && !seen) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (inject && k == 4) begin
                    start = 1'b1; a = 16'hFFFF; op = 2'b01;
                end
                if (inject && k == 5) start = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        chk({nm, "_latency"}, 64'(k), 64'd17);
        chk({nm, "_result"}, 64'(result), 64'(exp));
        @(negedge clk);
        chk({nm, "_busy_low"}, 64'(busy), 64'd0);
        chk({nm, "_done_low"}, 64'(done), 64'd0);
    endtask

    int n_done;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'h0);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        chk("rst_zero", 64'(zero), 64'd1);
`endif
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        run_op(2'b01, 16'h00F0, 16'h0F00, 16'h0FF0, "or", 1'b0);
        run_op(2'b00, 16'hFFFF, 16'h1234, 16'h1234, "and", 1'b0);
        run_op(2'b10, 16'hAAAA, 16'hFFFF, 16'h5555, "xor", 1'b0);
        run_op(2'b11, 16'hFF00, 16'h0FF0, 16'hF0FF, "nand", 1'b0);

        // start pulsed mid-run must be ignored
        run_op(2'b01, 16'h0001, 16'h0002, 16'h0003, "busy_start", 1'b1);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        chk("busy_start_no_extra_done", 64'(n_done), 64'd0);

        // reset in the middle of a run
        start = 1'b1; op = 2'b01; a = 16'h1234; b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", 64'(result), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        chk("midrst_no_done", 64'(n_done), 64'd0);
        chk("midrst_result_hold", 64'(result), 64'h0);

        // all-zero and all-ones results
        run_op(2'b00, 16'hF0F0, 16'h0F0F, 16'h0000, "and_zero", 1'b0);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        chk("zero_set", 64'(zero), 64'd1);
`endif
        run_op(2'b01, 16'hF0F0, 16'h0F0F, 16'hFFFF, "or_ones", 1'b0);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        chk("zero_clr", 64'(zero), 64'd0);
`endif
        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1);
    end
endmodule
